// File: rtl/nios_upc_nios2_qsys_0_oci_trace_pkg.sv
// Shared constants for the OCI debug-trace path: frame tags, atom codes,
// address-event kinds and the frame/buffer widths.
package nios_upc_nios2_qsys_0_oci_trace_pkg;

  localparam int unsigned FRAME_W   = 36;
  localparam int unsigned DCT_BUF_W = 30;
  localparam int unsigned TAG_W     = 2;

  // Frame tags carried in tr_data[35:34]
  localparam logic [1:0] TAG_DCT  = 2'b01;
  localparam logic [1:0] TAG_ADDR = 2'b10;
  localparam logic [1:0] TAG_OVF  = 2'b11;

  // Direct-branch atom codes; 00 and 11 carry no information
  localparam logic [1:0] ATOM_TAKEN     = 2'b01;
  localparam logic [1:0] ATOM_NOT_TAKEN = 2'b10;

  // Address-event kinds
  localparam logic [1:0] ADDR_INDIRECT  = 2'b00;
  localparam logic [1:0] ADDR_EXCEPTION = 2'b01;
  localparam logic [1:0] ADDR_SYNC      = 2'b10;

  function automatic logic atom_is_valid(input logic [1:0] a);
    return (a == ATOM_TAKEN) || (a == ATOM_NOT_TAKEN);
  endfunction

endpackage

// File: rtl/nios_upc_nios2_qsys_0_oci_dct_pack.sv
// DCT atom packer: shifts 2-bit atoms into the buffer (oldest atom in the
// upper bits), counts them and flags a full buffer.
// Ports: clk, reset (async, active-high), push/atom (append one atom),
// clear (frame loaded this cycle), dct_buffer, dct_count, full.
module nios_upc_nios2_qsys_0_oci_dct_pack #(
  parameter int unsigned DCT_DEPTH = 15,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [1:0]             atom,
  input  logic                   clear,
  output logic [2*DCT_DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   full
);

  localparam int unsigned BUF_W = 2 * DCT_DEPTH;

  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] cnt_next;

  // A push in the same cycle as a clear starts the next frame with that atom
  always_comb begin
    buf_next = dct_buffer;
    cnt_next = dct_count;
    if (clear) begin
      buf_next = push ? BUF_W'(atom) : '0;
      cnt_next = push ? CNT_W'(1) : '0;
    end else if (push) begin
      buf_next = {dct_buffer[BUF_W-3:0], atom};
      cnt_next = dct_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      full       <= 1'b0;
    end else begin
      dct_buffer <= buf_next;
      dct_count  <= cnt_next;
      full       <= (cnt_next == CNT_W'(DCT_DEPTH));
    end
  end

endmodule

// File: rtl/nios_upc_nios2_qsys_0_oci_dct_sched.sv
// Trace-frame scheduler: packs branch atoms into DCT frames, holds one
// pending address event, counts dropped events and multiplexes DCT,
// address and overflow frames onto one registered valid/ready output.
// Ports: clk, reset (async, active-high), trace_enable, atom_valid/atom,
// addr_valid/addr_kind/addr, tr_valid/tr_data/tr_ready, dct_buffer,
// dct_count, overflow.
module nios_upc_nios2_qsys_0_oci_dct_sched
  import nios_upc_nios2_qsys_0_oci_trace_pkg::*;
#(
  parameter int unsigned DCT_DEPTH = 15,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_enable,
  input  logic                   atom_valid,
  input  logic [1:0]             atom,
  input  logic                   addr_valid,
  input  logic [1:0]             addr_kind,
  input  logic [31:0]            addr,
  output logic                   tr_valid,
  output logic [FRAME_W-1:0]     tr_data,
  input  logic                   tr_ready,
  output logic [2*DCT_DEPTH-1:0] dct_buffer,
  output logic [3:0]             dct_count,
  output logic                   overflow
);

  localparam int unsigned CNT_W = 4;

  logic              full;
  logic              addr_pend;
  logic [1:0]        pend_kind;
  logic [31:0]       pend_addr;
  logic              flush_req;
  logic [DROP_W-1:0] drop_cnt;

  logic              slot_free, atom_ok, addr_ok, stall;
  logic              drop_atom, drop_addr, push, capture;
  logic              dct_want, ovf_load, dct_load, addr_load;
  logic              cnt_after_nz;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_next;
  logic [FRAME_W-1:0] ovf_frame;

  always_comb begin
    slot_free = !tr_valid || tr_ready;
    dct_want  = full || (flush_req && (dct_count != '0));
    ovf_load  = slot_free && (drop_cnt != '0);
    dct_load  = slot_free && !ovf_load && dct_want;
    // Address waits until any DCT frame it must follow has loaded
    addr_load = slot_free && !ovf_load && !dct_want && addr_pend && !flush_req;

    atom_ok   = trace_enable && atom_valid && atom_is_valid(atom);
    addr_ok   = trace_enable && addr_valid;
    // The atom arriving with the flushing DCT load belongs after the address
    stall     = flush_req && !dct_load;
    drop_atom = atom_ok && (stall || (full && !dct_load));
    push      = atom_ok && !drop_atom;
    drop_addr = addr_ok && addr_pend;
    capture   = addr_ok && !addr_pend;

    // Count once this cycle's atom is in, so a same-cycle atom precedes the address
    cnt_after_nz = dct_load ? push : ((dct_count != '0) || push);

    drop_sum  = {1'b0, (ovf_load ? '0 : drop_cnt)}
              + (DROP_W+1)'(drop_atom) + (DROP_W+1)'(drop_addr);
    drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

    ovf_frame = '0;
    ovf_frame[FRAME_W-1 -: TAG_W] = TAG_OVF;
    ovf_frame[DROP_W-1:0] = drop_cnt;
  end

  nios_upc_nios2_qsys_0_oci_dct_pack #(
    .DCT_DEPTH (DCT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_pack (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .atom       (atom),
    .clear      (dct_load),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .full       (full)
  );

  // Pending address entry, flush request and drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_pend <= 1'b0;
      pend_kind <= '0;
      pend_addr <= '0;
      flush_req <= 1'b0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        addr_pend <= 1'b1;
        pend_kind <= addr_kind;
        pend_addr <= addr;
        flush_req <= cnt_after_nz;
      end else begin
        if (addr_load) addr_pend <= 1'b0;
        if (dct_load)  flush_req <= 1'b0;
      end
      drop_cnt <= drop_next;
      overflow <= (drop_next != '0);
    end
  end

  // Output register: load by priority overflow > DCT > address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tr_valid <= 1'b0;
      tr_data  <= '0;
    end else if (slot_free) begin
      if (ovf_load) begin
        tr_valid <= 1'b1;
        tr_data  <= ovf_frame;
      end else if (dct_load) begin
        tr_valid <= 1'b1;
        tr_data  <= FRAME_W'({TAG_DCT, dct_count, dct_buffer});
      end else if (addr_load) begin
        tr_valid <= 1'b1;
        tr_data  <= FRAME_W'({TAG_ADDR, pend_kind, pend_addr});
      end else begin
        tr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_upc_nios2_qsys_0_oci_dct_sched.sv
// Self-checking bench for the trace-frame scheduler. Expected frames are
// queued as stimulus is driven and popped as the DUT transfers them.
module tb_nios_upc_nios2_qsys_0_oci_dct_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        addr_valid;
  logic [1:0]  addr_kind;
  logic [31:0] addr;
  logic        tr_valid;
  logic [35:0] tr_data;
  logic        tr_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  logic [35:0] frame_a;

  nios_upc_nios2_qsys_0_oci_dct_sched dut (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (trace_enable),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .addr_valid   (addr_valid),
    .addr_kind    (addr_kind),
    .addr         (addr),
    .tr_valid     (tr_valid),
    .tr_data      (tr_data),
    .tr_ready     (tr_ready),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] dct_f(input logic [3:0] c, input logic [29:0] b);
    return {2'b01, c, b};
  endfunction
  function automatic logic [35:0] addr_f(input logic [1:0] k, input logic [31:0] a);
    return {2'b10, k, a};
  endfunction
  function automatic logic [35:0] ovf_f(input logic [15:0] n);
    return {2'b11, 18'd0, n};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_atoms(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      atom_valid = 1'b1;
      atom       = a;
      step();
    end
    atom_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [1:0] k, input logic [31:0] a);
    addr_valid = 1'b1;
    addr_kind  = k;
    addr       = a;
    step();
    addr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk(tag, 36'(exp_q.size()), 36'd0);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected frame
  always @(negedge clk) begin
    if (!reset && tr_valid && tr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", tr_data, 36'd0);
        if (tr_data === 36'd0) begin
          n_err++;
          $error("FAIL unexpected_frame observed=%h expected=none", tr_data);
        end
      end else begin
        chk("frame", tr_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; trace_enable = 1'b1; tr_ready = 1'b1;
    atom_valid = 1'b0; atom = 2'b00;
    addr_valid = 1'b0; addr_kind = 2'b00; addr = 32'd0;
    step(); step();

    // Reset values
    chk("rst_tr_valid", 36'(tr_valid), 36'd0);
    chk("rst_tr_data", tr_data, 36'd0);
    chk("rst_buffer", 36'(dct_buffer), 36'd0);
    chk("rst_count", 36'(dct_count), 36'd0);
    chk("rst_overflow", 36'(overflow), 36'd0);
    reset = 1'b0;
    step();

    // Disabled trace ignores atoms; invalid codes ignored
    trace_enable = 1'b0;
    send_atoms(2'b01, 3);
    trace_enable = 1'b1;
    send_atoms(2'b11, 2);
    send_atoms(2'b00, 2);
    chk("disabled_count", 36'(dct_count), 36'd0);

    // Fill: 15 taken atoms make one full DCT frame
    exp_q.push_back(dct_f(4'd15, 30'h15555555));
    send_atoms(2'b01, 15);
    chk("fill_count15", 36'(dct_count), 36'd15);
    step();
    chk("fill_count0", 36'(dct_count), 36'd0);
    wait_drain("fill_drain");

    // Flush before address
    exp_q.push_back(dct_f(4'd3, 30'h19));
    exp_q.push_back(addr_f(2'b00, 32'h0000_1000));
    send_atoms(2'b01, 1);
    send_atoms(2'b10, 1);
    send_atoms(2'b01, 1);
    chk("flush_buffer", 36'(dct_buffer), 36'h19);
    send_addr(2'b00, 32'h0000_1000);
    wait_drain("flush_drain");
    step();

    // Backpressure: stuck full frame, refilled buffer, 4 drops
    tr_ready = 1'b0;
    frame_a = dct_f(4'd15, 30'h15555555);
    exp_q.push_back(frame_a);
    exp_q.push_back(ovf_f(16'd4));
    exp_q.push_back(dct_f(4'd15, 30'h2AAAAAAA));
    send_atoms(2'b01, 15);
    step();
    chk("bp_held_a", tr_data, frame_a);
    send_atoms(2'b10, 15);
    send_atoms(2'b01, 4);
    chk("bp_overflow", 36'(overflow), 36'd1);
    chk("bp_stable", tr_data, frame_a);
    chk("bp_buffer", 36'(dct_buffer), 36'h2AAAAAAA);
    step(); step();
    chk("bp_stable2", tr_data, frame_a);
    tr_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_overflow_clear", 36'(overflow), 36'd0);

    // Atom in the same cycle a full buffer loads
    exp_q.push_back(dct_f(4'd15, 30'h2AAAAAAA));
    exp_q.push_back(dct_f(4'd1, 30'h1));
    exp_q.push_back(addr_f(2'b01, 32'hDEAD_BEEF));
    send_atoms(2'b10, 15);
    send_atoms(2'b01, 1);
    chk("simul_count", 36'(dct_count), 36'd1);
    chk("simul_buffer", 36'(dct_buffer), 36'h1);
    send_addr(2'b01, 32'hDEAD_BEEF);
    wait_drain("simul_drain");
    step();

    // Double address under backpressure
    tr_ready = 1'b0;
    exp_q.push_back(addr_f(2'b10, 32'hA5A5_0001));
    exp_q.push_back(ovf_f(16'd1));
    addr_valid = 1'b1; addr_kind = 2'b10; addr = 32'hA5A5_0001;
    step();
    addr_kind = 2'b11; addr = 32'h1234_5678;
    step();
    addr_valid = 1'b0;
    chk("dbl_overflow", 36'(overflow), 36'd1);
    chk("dbl_held", tr_data, addr_f(2'b10, 32'hA5A5_0001));
    tr_ready = 1'b1;
    wait_drain("dbl_drain");
    step();

    // Reset while a frame is waiting on the output
    tr_ready = 1'b0;
    send_addr(2'b00, 32'h0000_0055);
    send_atoms(2'b01, 2);
    chk("rmid_valid_before", 36'(tr_valid), 36'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_tr_valid", 36'(tr_valid), 36'd0);
    chk("rmid_tr_data", tr_data, 36'd0);
    chk("rmid_count", 36'(dct_count), 36'd0);
    chk("rmid_buffer", 36'(dct_buffer), 36'd0);
    chk("rmid_overflow", 36'(overflow), 36'd0);
    step();
    reset = 1'b0;
    tr_ready = 1'b1;
    repeat (6) step();
    chk("resume_valid", 36'(tr_valid), 36'd0);
    chk("resume_count", 36'(dct_count), 36'd0);
    chk("resume_queue", 36'(exp_q.size()), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
